// File: rtl/soc_mem_arb.sv
// soc_mem_arb: N-port shared data memory with round-robin arbitration and configurable read latency.
// Define SOC_MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest port index wins).
module soc_mem_arb #(
  parameter  int NUM_PORTS  = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 16,
  parameter  int RD_LATENCY = 1,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_err,
  output logic                             busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         w_gidx;
  logic [PW-1:0]         r_gidx;
  logic [NUM_PORTS-1:0]  w_grant;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_accept;
  logic                  w_load_rd;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_inrange;
  logic                  w_wr_inrange;

  // Later (lower-offset) matches overwrite earlier ones, so the port nearest the pointer wins.
  always_comb begin
    int c;
    c       = 0;
    w_grant = '0;
    w_gidx  = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      c = int'(w_ptr) + k;
      if (c >= NUM_PORTS) c = c - NUM_PORTS;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (c == j && req_valid[j]) begin
          w_grant    = '0;
          w_grant[j] = 1'b1;
          w_gidx     = PW'(j);
        end
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (w_grant[j]) begin
        w_we    = req_we[j];
        w_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready = (r_state == IDLE && !reset) ? w_grant : '0;
  assign w_accept  = |req_ready;
  assign busy      = (r_state != IDLE);

`ifdef SOC_MEM_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (int'(w_gidx) == NUM_PORTS-1) ? '0 : w_gidx + PW'(1);
    end
  end

  assign w_ptr = r_ptr;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_rd   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_we) begin
            w_state_nxt = RESP;
          end else if (RD_LATENCY == 1) begin
            w_state_nxt = RESP;
            w_load_rd   = 1'b1;
          end else begin
            w_state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = RESP;
          w_load_rd   = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read data is sampled on the edge that enters RESP; from IDLE that is the accept edge itself.
  assign w_rd_addr    = (r_state == IDLE) ? w_addr : r_addr;
  assign w_rd_inrange = ({1'b0, w_rd_addr} < DEPTH_EXT);
  assign w_wr_inrange = ({1'b0, w_addr} < DEPTH_EXT);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_gidx <= w_gidx;
      r_we   <= w_we;
      r_addr <= w_addr;
      r_cnt  <= CW'(RD_LATENCY - 1);
    end else if (r_state == RD_WAIT) begin
      r_cnt  <= r_cnt - CW'(1);
    end
    if (w_load_rd) r_rdata <= w_rd_inrange ? r_mem[w_rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_accept && w_we && w_wr_inrange) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  assign rsp_valid = (r_state == RESP) ? (NUM_PORTS'(1) << r_gidx) : '0;
  assign rsp_err   = (r_state == RESP) && ({1'b0, r_addr} >= DEPTH_EXT);
  assign rsp_data  = (r_state == RESP && !r_we) ? r_rdata : '0;

endmodule

// File: tb/tb_soc_mem_arb.sv
// Testbench for soc_mem_arb: instance A (2 ports, depth 16, latency 1) and instance B (3 ports, depth 12, latency 4).
module tb_soc_mem_arb;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  a_req_valid, a_req_we, a_req_ready, a_rsp_valid;
  logic [3:0]  a_addr [2];
  logic [31:0] a_wdata [2];
  logic [7:0]  a_req_addr;
  logic [63:0] a_req_wdata;
  logic [31:0] a_rsp_data;
  logic        a_rsp_err, a_busy;
  assign a_req_addr  = {a_addr[1], a_addr[0]};
  assign a_req_wdata = {a_wdata[1], a_wdata[0]};

  logic [2:0]  b_req_valid, b_req_we, b_req_ready, b_rsp_valid;
  logic [3:0]  b_addr [3];
  logic [15:0] b_wdata [3];
  logic [11:0] b_req_addr;
  logic [47:0] b_req_wdata;
  logic [15:0] b_rsp_data;
  logic        b_rsp_err, b_busy;
  assign b_req_addr  = {b_addr[2], b_addr[1], b_addr[0]};
  assign b_req_wdata = {b_wdata[2], b_wdata[1], b_wdata[0]};

  soc_mem_arb #(.NUM_PORTS(2), .DATA_WIDTH(32), .MEM_DEPTH(16), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  soc_mem_arb #(.NUM_PORTS(3), .DATA_WIDTH(16), .MEM_DEPTH(12), .RD_LATENCY(4)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic a_xact(input int p, input logic we, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_data, input string nm);
    int lat;
    bit got;
    @(posedge clk); #1;
    a_req_valid = '0; a_req_valid[p] = 1'b1; a_req_we[p] = we; a_addr[p] = addr; a_wdata[p] = wd;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (a_req_ready[p]) got = 1'b1;
    end
    check({nm, "_grant"}, a_req_ready, 64'(2'b01 << p));
    @(posedge clk); #1 a_req_valid = '0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (a_rsp_valid == '0 && lat < 8);
    check({nm, "_lat"}, lat, 1);
    check({nm, "_rsp_valid"}, a_rsp_valid, 64'(2'b01 << p));
    check({nm, "_data"}, a_rsp_data, exp_data);
    check({nm, "_err"}, a_rsp_err, 0);
  endtask

  // Waits for the response while the other ports keep requesting; busy must stay high and ready low.
  task automatic b_wait_rsp(input int p, input int exp_lat, input logic [15:0] exp_data,
                            input logic exp_err, input string nm);
    int lat;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      check({nm, "_busy"}, b_busy, 1);
      check({nm, "_rdy_low"}, b_req_ready, 0);
    end while (b_rsp_valid == '0 && lat < 10);
    check({nm, "_lat"}, lat, exp_lat);
    check({nm, "_rsp_valid"}, b_rsp_valid, 64'(3'b001 << p));
    check({nm, "_data"}, b_rsp_data, exp_data);
    check({nm, "_err"}, b_rsp_err, exp_err);
  endtask

  task automatic b_xact(input int p, input logic we, input logic [3:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_data, input logic exp_err, input string nm);
    bit got;
    @(posedge clk); #1;
    b_req_valid = '0; b_req_valid[p] = 1'b1; b_req_we[p] = we; b_addr[p] = addr; b_wdata[p] = wd;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (b_req_ready[p]) got = 1'b1;
    end
    check({nm, "_grant"}, b_req_ready, 64'(3'b001 << p));
    @(posedge clk); #1;
    b_req_we    = '0;
    b_req_valid = 3'b111 ^ (3'b001 << p);
    b_wait_rsp(p, we ? 1 : 4, exp_data, exp_err, nm);
    @(posedge clk); #1 b_req_valid = '0;
  endtask

  task automatic b_new_req(input int i);
    b_req_valid[i] = 1'b1;
    b_req_we[i]    = 1'($urandom_range(0, 1));
    b_addr[i]      = 4'($urandom_range(0, 13));
    b_wdata[i]     = 16'($urandom);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl [10];
  logic [1:0]  grants [4];
  int          ng, ncyc;

  logic [15:0] m_mem [12];
  int          m_ptr, m_free, m_rcyc, m_lat, w;
  bit          m_pend, e_busy;
  logic [2:0]  m_roh, e_rdy, granted;
  logic [15:0] m_rdata;
  logic        m_rerr, m_we;
  logic [3:0]  m_addr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1'b0, 4'd5,  32'h0,        32'h0};
    tbl[1] = '{0, 1'b1, 4'd3,  32'hDEADBEEF, 32'h0};
    tbl[2] = '{1, 1'b0, 4'd3,  32'h0,        32'hDEADBEEF};
    tbl[3] = '{1, 1'b1, 4'd15, 32'h12345678, 32'h0};
    tbl[4] = '{0, 1'b0, 4'd15, 32'h0,        32'h12345678};
    tbl[5] = '{1, 1'b1, 4'd0,  32'hA5A5A5A5, 32'h0};
    tbl[6] = '{0, 1'b0, 4'd0,  32'h0,        32'hA5A5A5A5};
    tbl[7] = '{1, 1'b1, 4'd3,  32'h0BADF00D, 32'h0};
    tbl[8] = '{1, 1'b0, 4'd3,  32'h0,        32'h0BADF00D};
    tbl[9] = '{0, 1'b0, 4'd14, 32'h0,        32'h0};

    a_req_valid = '0; a_req_we = '0; b_req_valid = '0; b_req_we = '0;
    for (int i = 0; i < 2; i++) begin a_addr[i] = '0; a_wdata[i] = '0; end
    for (int i = 0; i < 3; i++) begin b_addr[i] = '0; b_wdata[i] = '0; end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_a_ready", a_req_ready, 0);
    check("rst_a_rsp_valid", a_rsp_valid, 0);
    check("rst_a_data", a_rsp_data, 0);
    check("rst_a_err", a_rsp_err, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_b_ready", b_req_ready, 0);
    check("rst_b_rsp_valid", b_rsp_valid, 0);
    check("rst_b_data", b_rsp_data, 0);
    check("rst_b_err", b_rsp_err, 0);
    check("rst_b_busy", b_busy, 0);

    // Both A ports hold read requests continuously.
    @(posedge clk); #1;
    a_req_valid = 2'b11; a_req_we = 2'b00; a_addr[0] = 4'd1; a_addr[1] = 4'd2;
    ng = 0; ncyc = 0;
    while (ng < 4 && ncyc < 40) begin
      @(negedge clk); ncyc++;
      if (a_req_ready != '0) begin grants[ng] = a_req_ready; ng++; end
    end
    @(posedge clk); #1 a_req_valid = '0;
    check("arb_grant_count", ng, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef SOC_MEM_ARB_FIXED_PRIO_EN
      check("arb_fixed_grant", grants[k], 2'b01);
`else
      check("arb_rr_grant", grants[k], (k % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end
    repeat (3) @(posedge clk);

    for (int i = 0; i < 10; i++)
      a_xact(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_data, $sformatf("a_vec%0d", i));

    b_xact(0, 1'b1, 4'd13, 16'h0055, 16'h0, 1'b1, "b_wr_oob");
    b_xact(1, 1'b0, 4'd13, 16'h0,    16'h0, 1'b1, "b_rd_oob");
    b_xact(1, 1'b0, 4'd1,  16'h0,    16'h0, 1'b0, "b_rd_alias1");
    b_xact(2, 1'b0, 4'd5,  16'h0,    16'h0, 1'b0, "b_rd_alias5");
    b_xact(2, 1'b1, 4'd11, 16'hBEEF, 16'h0, 1'b0, "b_wr_top");
    b_xact(0, 1'b0, 4'd11, 16'h0,    16'hBEEF, 1'b0, "b_rd_top");
    b_xact(2, 1'b1, 4'd5,  16'h1234, 16'h0, 1'b0, "b_wr5");

    // Reset lands while port 1's read is in RD_WAIT.
    @(posedge clk); #1;
    b_req_valid = 3'b010; b_req_we = '0; b_addr[1] = 4'd5;
    ncyc = 0;
    do begin @(negedge clk); ncyc++; end while (b_req_ready != 3'b010 && ncyc < 8);
    check("rst_mid_grant", b_req_ready, 3'b010);
    @(posedge clk); #1 b_req_valid = '0;
    @(negedge clk);
    check("rst_mid_busy_before", b_busy, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_busy_after", b_busy, 0);
      check("rst_mid_no_rsp", b_rsp_valid, 0);
    end
    @(posedge clk); #1;
    b_req_valid = 3'b111; b_req_we = '0;
    for (int i = 0; i < 3; i++) b_addr[i] = 4'd5;
    @(negedge clk);
    check("rst_mid_ptr0_grant", b_req_ready, 3'b001);
    @(posedge clk); #1 b_req_valid = 3'b110;
    b_wait_rsp(0, 4, 16'h0, 1'b0, "rst_mid_mem_cleared");
    @(posedge clk); #1 b_req_valid = '0;

    // Randomised traffic on instance B against a transaction-level model.
    do_reset(2);
    for (int i = 0; i < 12; i++) m_mem[i] = '0;
    m_ptr = 0; m_free = 0; m_rcyc = 0; m_pend = 1'b0; m_roh = '0; m_rdata = '0; m_rerr = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      e_busy = (c < m_free);
      w = -1;
      if (!e_busy) begin
        for (int k = 0; k < 3; k++) begin
          if (w < 0 && b_req_valid[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
        end
      end
      e_rdy = (w >= 0) ? 3'(3'b001 << w) : 3'b000;
      check("rnd_ready", b_req_ready, e_rdy);
      check("rnd_busy", b_busy, e_busy);
      if (m_pend && c == m_rcyc) begin
        check("rnd_rsp_valid", b_rsp_valid, m_roh);
        check("rnd_rsp_data", b_rsp_data, m_rdata);
        check("rnd_rsp_err", b_rsp_err, m_rerr);
        m_pend = 1'b0;
      end else begin
        check("rnd_rsp_quiet", b_rsp_valid, 0);
      end
      if (w >= 0) begin
        m_we   = b_req_we[w];
        m_addr = b_addr[w];
        m_rerr = (m_addr >= 4'd12);
        if (m_we) begin
          if (!m_rerr) m_mem[m_addr] = b_wdata[w];
          m_rdata = '0;
          m_lat   = 1;
        end else begin
          m_rdata = m_rerr ? 16'h0 : m_mem[m_addr];
          m_lat   = 4;
        end
        m_rcyc = c + m_lat;
        m_free = c + 1 + m_lat;
        m_pend = 1'b1;
        m_roh  = e_rdy;
`ifdef SOC_MEM_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (w + 1) % 3;
`endif
      end
      granted = e_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (granted[i]) begin
          if ($urandom_range(0, 1) == 1) b_new_req(i);
          else b_req_valid[i] = 1'b0;
        end else if (b_req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) b_req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          b_new_req(i);
        end
      end
    end
    b_req_valid = '0;
    repeat (6) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/soc_mem_arb.md
Name: soc_mem_arb

Overview:
- Parametrised shared data memory for the SOC with N requester ports and round-robin arbitration.
- Each port uses a valid/ready request handshake and receives a single-cycle response pulse.
- Configurable read latency.
- Successor to the single-requester SOC memory: generalised in port count, width, depth and latency; adds arbitration, out-of-range error reporting and write acknowledgement.

Parameters:
- NUM_PORTS, 2, number of requester ports (>=1)
- DATA_WIDTH, 32, data word width in bits
- MEM_DEPTH, 16, number of words (any value >=2; not required to be a power of two)
- RD_LATENCY, 1, cycles from read accept edge to rsp_valid (>=1)
- ADDR_WIDTH, $clog2(MEM_DEPTH), derived localparam

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_we  in  NUM_PORTS  per-port write enable (1=write, 0=read)
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_PORTS  one-hot grant; request accepted when req_valid[i]&req_ready[i]
- rsp_valid  out  NUM_PORTS  one-hot, one-cycle response pulse to the owning port
- rsp_data  out  DATA_WIDTH  read data, valid only with rsp_valid on a read
- rsp_err  out  1  address >= MEM_DEPTH, valid with rsp_valid
- busy  out  1  high whenever FSM not in IDLE

Behaviour:
- Reset (sync, active-high) values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - FSM=IDLE; round-robin pointer=0 (port 0 highest priority).
  - All memory words cleared to 0.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot to the first requesting port searching from pointer upward, wrapping at NUM_PORTS.
  - req_ready is 0 if no req_valid is high.
  - On the accept edge, capture port index g, we, addr and wdata; pointer <= (g+1) mod NUM_PORTS.
  - Write accept: memory[addr] <= wdata at the accept edge if addr<MEM_DEPTH, else dropped. Next state RESP.
  - Read accept: next state RD_WAIT with counter=RD_LATENCY-1; if RD_LATENCY==1, go directly to RESP.
- RD_WAIT: counter decrements each cycle; at 0, register memory[addr] (0 if out of range) and go to RESP.
- RESP (one cycle):
  - rsp_valid[g]=1; rsp_err=(addr>=MEM_DEPTH); rsp_data = read word (reads) or 0 (writes).
  - Next state IDLE.
- req_ready is 0 in RD_WAIT and RESP; at most one transaction is outstanding.
- Latency from accept edge to rsp_valid:
  - writes: 1 cycle
  - reads: RD_LATENCY cycles
- Next accept is possible in the cycle after RESP.
- Read-after-write to the same address by any port returns the new data; the write commits before any later accept.
- Simultaneous requests: exactly one granted per IDLE cycle. Losers must hold req_valid and their request fields stable until granted.
- A requester dropping req_valid before its grant is legal; no response is generated.
- Reset asserted mid-transaction: the transaction is abandoned, no rsp_valid is issued, and the FSM returns to IDLE next cycle. A write already committed at its accept edge is then cleared by the memory reset.
- NUM_PORTS==1: the pointer is constant 0 and behaviour is otherwise identical.

Optional Feature:
- Macro: SOC_MEM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest port index wins. The pointer register is not implemented and always behaves as 0.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset 3 cycles, then idle: all outputs 0, busy=0. Read any address → rsp_data=0 (memory cleared).
- Port0 write addr 3 data 0xDEADBEEF → rsp_valid[0] one cycle after accept, rsp_err=0. Port1 read addr 3 → rsp_data=0xDEADBEEF exactly RD_LATENCY cycles after accept.
- Ports 0 and 1 both hold read requests continuously (NUM_PORTS=2) → grants alternate 0,1,0,1. With SOC_MEM_ARB_FIXED_PRIO_EN, port 0 is granted every time.
- MEM_DEPTH=12, write addr 13 data 0x55 → rsp_err=1, no memory change. Read addr 13 → rsp_data=0, rsp_err=1.
- RD_LATENCY=4, read accepted at cycle T → rsp_valid at T+4, busy high T+1..T+4, req_ready low throughout.
- Assert reset during RD_WAIT → no rsp_valid, busy=0 the cycle after reset, pointer back to 0.
